// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding access, EXU in, WBU out.
// Optional `LSU_MISALIGN_CHECK_EN faults misaligned half/word accesses.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_src2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_fault,
    output logic        out_is_load
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] wait_cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic [31:0] addr;
    logic        is_ld;
    logic        is_st;
    logic        ld_ok;
    logic        st_ok;
    logic        misalign;
    logic        bad;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] shifted;
    logic [31:0] ld_data;

    assign addr  = in_src1 + in_imm;
    assign is_ld = (in_opcode == OP_LOAD);
    assign is_st = (in_opcode == OP_STORE);
    assign ld_ok = in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign st_ok = in_funct3 inside {3'b000, 3'b001, 3'b010};

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = ((in_funct3[1:0] == 2'b01) && addr[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad = (is_ld ? !ld_ok : !st_ok) || misalign;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);

    // Replicate store data so the addressed lanes carry it; upper bits fall off
    always_comb begin
        st_wdata = in_src2;
        st_wstrb = 4'b1111;
        case (in_funct3[1:0])
            2'b00: begin
                st_wdata = {4{in_src2[7:0]}};
                st_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{in_src2[15:0]}};
                st_wstrb = 4'b0011 << addr[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {24'd0, shifted[7:0]};
            3'b101:  ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 16'd0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_wstrb   <= 4'd0;
            out_rdata   <= 32'd0;
            out_fault   <= 1'b0;
            out_is_load <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_rdata <= 32'd0;
                        out_fault <= 1'b0;
                        wait_cnt  <= 16'd0;
                        if (is_ld || is_st) begin
                            out_is_load <= is_ld;
                            funct3_q    <= in_funct3;
                            off_q       <= addr[1:0];
                            if (bad) begin
                                out_fault <= 1'b1;
                                state     <= RESP;
                            end else begin
                                mem_req   <= 1'b1;
                                mem_we    <= is_st;
                                mem_addr  <= {addr[31:2], 2'b00};
                                mem_wdata <= is_st ? st_wdata : 32'd0;
                                mem_wstrb <= is_st ? st_wstrb : 4'd0;
                                state     <= REQ;
                            end
                        end else begin
                            out_is_load <= 1'b0;
                            state       <= RESP;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        out_fault <= mem_err;
                        out_rdata <= out_is_load ? ld_data : 32'd0;
                        state     <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        out_fault <= 1'b1;
                        out_rdata <= 32'd0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a scripted memory responder.
// Misalignment expectations follow LSU_MISALIGN_CHECK_EN.
module tb_lsu_ctrl;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_RR = 7'b0110011;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
        logic        is_load;
        logic [7:0]  lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [31:0] in_src1;
    logic [31:0] in_imm;
    logic [31:0] in_src2;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_fault;
    logic        out_is_load;

    int checks = 0;
    int failures = 0;

    exp_t exp_q[$];
    exp_t e;

    logic [31:0] o_rdata;
    logic        o_fault;
    logic        o_is_load;
    logic        o_rdy_pre;
    logic        o_rdy_resp;
    int          lat;
    int          wcnt;
    int          req_cyc;
    int          n_gnt;
    int          rcnt;
    logic        req_seen;
    logic        req_unstable;
    logic        out_unstable;
    logic        extra;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_src1(in_src1), .in_imm(in_imm), .in_src2(in_src2),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_fault(out_fault),
        .out_is_load(out_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, play memory with the given delays, record what came out
    task automatic run_txn(
        input logic [6:0] op, input logic [2:0] f3,
        input logic [31:0] s1, input logic [31:0] imm, input logic [31:0] s2,
        input int gw, input int rw, input logic [31:0] rd,
        input logic err, input logic rv_en, input int ready_w,
        input logic late_rv
    );
        int cyc;
        logic phase;
        logic done;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
        mem_err = 1'b0;
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3;
        in_src1 = s1; in_imm = imm; in_src2 = s2;
        o_rdy_pre = in_ready;
        tick();
        in_valid = 1'b0;
        cyc = 1; phase = 1'b0; done = 1'b0;
        wcnt = 0; req_cyc = 0; n_gnt = 0; rcnt = 0; lat = 0;
        req_seen = 1'b0; req_unstable = 1'b0; out_unstable = 1'b0;
        extra = 1'b0;
        o_rdata = '0; o_fault = 1'b0; o_is_load = 1'b0; o_rdy_resp = 1'b1;
        r_we = 1'b0; r_addr = '0; r_wdata = '0; r_wstrb = '0;
        while (!done) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
            mem_err = 1'b0;
            if (out_valid) begin
                if (rcnt == 0) begin
                    lat = cyc; o_rdata = out_rdata; o_fault = out_fault;
                    o_is_load = out_is_load; o_rdy_resp = in_ready;
                end else if ({out_rdata, out_fault, out_is_load} !==
                             {o_rdata, o_fault, o_is_load}) begin
                    out_unstable = 1'b1;
                end
                rcnt++;
                if (rcnt > ready_w) begin
                    out_ready = 1'b1;
                    done = 1'b1;
                end
            end else if (mem_req) begin
                if (req_cyc == 0) begin
                    r_we = mem_we; r_addr = mem_addr;
                    r_wdata = mem_wdata; r_wstrb = mem_wstrb;
                end else if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !==
                             {r_we, r_addr, r_wdata, r_wstrb}) begin
                    req_unstable = 1'b1;
                end
                req_seen = 1'b1;
                req_cyc++;
                if (req_cyc > gw) begin
                    mem_gnt = 1'b1;
                    n_gnt++;
                    phase = 1'b1;
                end
            end else if (phase) begin
                wcnt++;
                if (rv_en && wcnt > rw) begin
                    mem_rvalid = 1'b1; mem_rdata = rd; mem_err = err;
                end
            end
            tick();
            cyc++;
            if (cyc > 200 && !done) begin
                checks++; failures++;
                $display("FAIL txn_bound got=%0d cycles limit=200", cyc);
                done = 1'b1;
            end
        end
        out_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = late_rv && (i == 0);
            mem_rdata = 32'h5A5A5A5A;
            tick();
            if (out_valid || mem_req || !in_ready) extra = 1'b1;
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({in_ready, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata} !==
            {1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_mem got=%b%b%b %h %h %h want=1 0 0 0 0 0",
                     in_ready, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata);
        end
        checks++;
        if ({out_valid, out_rdata, out_fault, out_is_load} !== 35'd0) begin
            failures++;
            $display("FAIL reset_out got=%b %h %b %b want=0 0 0 0",
                     out_valid, out_rdata, out_fault, out_is_load);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lw_basic();
        exp_q.push_back('{32'hDEADBEEF, 1'b0, 1'b1, 8'd3});
        run_txn(OP_LD, 3'b010, 32'h80000000, 32'd4, 32'd0,
                0, 0, 32'hDEADBEEF, 1'b0, 1'b1, 0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (r_addr !== 32'h80000004) begin
            failures++; $display("FAIL lw_addr got=%h want=80000004", r_addr);
        end
        checks++;
        if ({o_rdata, o_fault, o_is_load} !== {e.rdata, e.fault, e.is_load}) begin
            failures++;
            $display("FAIL lw_out got=%h %b %b want=%h %b %b",
                     o_rdata, o_fault, o_is_load, e.rdata, e.fault, e.is_load);
        end
        checks++;
        if (lat !== int'(e.lat)) begin
            failures++; $display("FAIL lw_latency got=%0d want=%0d", lat, e.lat);
        end
        checks++;
        if ({r_we, r_wstrb} !== 5'd0) begin
            failures++; $display("FAIL lw_we_strb got=%b %b want=0 0000", r_we, r_wstrb);
        end
        checks++;
        if ({o_rdy_pre, o_rdy_resp} !== 2'b10) begin
            failures++;
            $display("FAIL in_ready got=%b%b want=10", o_rdy_pre, o_rdy_resp);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] offs[4] = '{32'd3, 32'd3, 32'd2, 32'd2};
        logic [31:0] want[4] = '{32'hFFFFFF80, 32'h00000080,
                                 32'hFFFF8012, 32'h00008012};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{want[i], 1'b0, 1'b1, 8'd3});
            run_txn(OP_LD, f3s[i], 32'h00001000, offs[i], 32'd0,
                    0, 0, 32'h80123456, 1'b0, 1'b1, 0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({o_rdata, o_fault, r_addr} !== {e.rdata, e.fault, 32'h1000}) begin
                failures++;
                $display("FAIL load_ext%0d got=%h %b %h want=%h %b 00001000",
                         i, o_rdata, o_fault, r_addr, e.rdata, e.fault);
            end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3s [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] s1s [3] = '{32'h00002000, 32'h00002000, 32'hFFFFFFFC};
        logic [31:0] imms[3] = '{32'd2, 32'd1, 32'd8};
        logic [31:0] s2s [3] = '{32'h0000ABCD, 32'h12345678, 32'hA5A5A5A5};
        logic [31:0] wa  [3] = '{32'h00002000, 32'h00002000, 32'h00000004};
        logic [31:0] wd  [3] = '{32'hABCDABCD, 32'h78787878, 32'hA5A5A5A5};
        logic [3:0]  ws  [3] = '{4'b1100, 4'b0010, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{32'd0, 1'b0, 1'b0, 8'd3});
            run_txn(OP_ST, f3s[i], s1s[i], imms[i], s2s[i],
                    0, 0, 32'hFFFFFFFF, 1'b0, 1'b1, 0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({r_we, r_addr, r_wdata, r_wstrb} !== {1'b1, wa[i], wd[i], ws[i]}) begin
                failures++;
                $display("FAIL store_req%0d got=%b %h %h %b want=1 %h %h %b",
                         i, r_we, r_addr, r_wdata, r_wstrb, wa[i], wd[i], ws[i]);
            end
            checks++;
            if ({o_rdata, o_fault, o_is_load} !== {e.rdata, e.fault, e.is_load}) begin
                failures++;
                $display("FAIL store_out%0d got=%h %b %b want=%h %b %b",
                         i, o_rdata, o_fault, o_is_load, e.rdata, e.fault, e.is_load);
            end
        end
    endtask

    task automatic test_stall();
        exp_q.push_back('{32'hCAFEF00D, 1'b0, 1'b1, 8'd8});
        run_txn(OP_LD, 3'b010, 32'h00005000, 32'd0, 32'd0,
                5, 0, 32'hCAFEF00D, 1'b0, 1'b1, 3, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({req_unstable, out_unstable, extra} !== 3'b000) begin
            failures++;
            $display("FAIL stall_stable got=%b%b%b want=000",
                     req_unstable, out_unstable, extra);
        end
        checks++;
        if (n_gnt != 1 || req_cyc != 6 || rcnt != 4) begin
            failures++;
            $display("FAIL stall_counts got=gnt%0d req%0d resp%0d want=gnt1 req6 resp4",
                     n_gnt, req_cyc, rcnt);
        end
        checks++;
        if (o_rdata !== e.rdata || lat !== int'(e.lat)) begin
            failures++;
            $display("FAIL stall_out got=%h lat%0d want=%h lat%0d",
                     o_rdata, lat, e.rdata, e.lat);
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back('{32'd0, 1'b1, 1'b1, 8'd6});
        run_txn(OP_LD, 3'b010, 32'h00004000, 32'd0, 32'd0,
                0, 0, 32'h11111111, 1'b0, 1'b0, 0, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if ({o_rdata, o_fault} !== {e.rdata, e.fault} || wcnt != 4) begin
            failures++;
            $display("FAIL timeout got=%h %b wait%0d want=%h %b wait4",
                     o_rdata, o_fault, wcnt, e.rdata, e.fault);
        end
        checks++;
        if (extra !== 1'b0 || lat !== int'(e.lat)) begin
            failures++;
            $display("FAIL late_rvalid got=extra%b lat%0d want=extra0 lat%0d",
                     extra, lat, e.lat);
        end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_CHECK_EN
        exp_q.push_back('{32'd0, 1'b1, 1'b1, 8'd1});
`else
        exp_q.push_back('{32'h00112233, 1'b0, 1'b1, 8'd3});
`endif
        run_txn(OP_LD, 3'b010, 32'h00003000, 32'd1, 32'd0,
                0, 0, 32'h11223344, 1'b0, 1'b1, 0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({o_rdata, o_fault, lat[7:0]} !== {e.rdata, e.fault, e.lat}) begin
            failures++;
            $display("FAIL misalign_out got=%h %b lat%0d want=%h %b lat%0d",
                     o_rdata, o_fault, lat, e.rdata, e.fault, e.lat);
        end
        checks++;
        if (req_seen !== !e.fault) begin
            failures++;
            $display("FAIL misalign_req got=%b want=%b", req_seen, !e.fault);
        end
    endtask

    task automatic test_no_mem();
        logic [6:0] ops[3] = '{OP_RR, OP_LD, OP_ST};
        logic [2:0] f3s[3] = '{3'b000, 3'b011, 3'b100};
        logic       flt[3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{32'd0, flt[i], 1'b0, 8'd1});
            run_txn(ops[i], f3s[i], 32'h00006000, 32'd0, 32'h12345678,
                    0, 0, 32'h0, 1'b0, 1'b1, 0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({o_rdata, o_fault, req_seen, lat[7:0]} !==
                {e.rdata, e.fault, 1'b0, e.lat}) begin
                failures++;
                $display("FAIL no_mem%0d got=%h %b req%b lat%0d want=%h %b req0 lat%0d",
                         i, o_rdata, o_fault, req_seen, lat, e.rdata, e.fault, e.lat);
            end
        end
        checks++;
        if (o_is_load !== 1'b0) begin
            failures++; $display("FAIL pass_is_load got=%b want=0", o_is_load);
        end
    endtask

    task automatic test_mem_err();
        exp_q.push_back('{32'h0, 1'b1, 1'b1, 8'd4});
        run_txn(OP_LD, 3'b010, 32'h00007000, 32'd0, 32'd0,
                0, 1, 32'h00000042, 1'b1, 1'b1, 0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (o_fault !== e.fault || lat !== int'(e.lat)) begin
            failures++;
            $display("FAIL mem_err got=%b lat%0d want=%b lat%0d",
                     o_fault, lat, e.fault, e.lat);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_opcode = OP_ST; in_funct3 = 3'b010;
        in_src1 = 32'h00008000; in_imm = 32'd0; in_src2 = 32'h99999999;
        mem_gnt = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++; $display("FAIL mid_req got=%b want=1", mem_req);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({in_ready, mem_req, mem_we, mem_addr, out_valid} !==
            {1'b1, 1'b0, 1'b0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset got=%b %b %b %h %b want=1 0 0 0 0",
                     in_ready, mem_req, mem_we, mem_addr, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data[2] = '{32'h01020304, 32'hF0E0D0C0};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{data[i], 1'b0, 1'b1, 8'd3});
        end
        for (int i = 0; i < 2; i++) begin
            run_txn(OP_LD, 3'b010, 32'h00009000, 32'(i * 4), 32'd0,
                    0, 0, data[i], 1'b0, 1'b1, 0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({o_rdata, o_rdy_pre, r_addr} !== {e.rdata, 1'b1, 32'h9000 + 32'(i * 4)}) begin
                failures++;
                $display("FAIL b2b%0d got=%h rdy%b %h want=%h rdy1 %h",
                         i, o_rdata, o_rdy_pre, r_addr, e.rdata, 32'h9000 + 32'(i * 4));
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0;
        in_src1 = '0; in_imm = '0; in_src2 = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        out_ready = 1'b0;
        tick();
        test_reset();
        test_lw_basic();
        test_load_ext();
        test_store();
        test_stall();
        test_timeout();
        test_misalign();
        test_no_mem();
        test_mem_err();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
